// File: rtl/adder_pkg.sv
// Shared types for the adder result path: flag bit positions, result record and FIFO occupancy states.
// Consumers index flags with FLG_* so the {V,N,Z,C} ordering lives in one place.
package adder_pkg;

    localparam int ADDER_W = 32;
    localparam int FLG_W   = 4;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    typedef struct packed {
        logic [FLG_W-1:0]   flags;
        logic [ADDER_W-1:0] sum;
    } adder_result_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/result_fifo2.sv
// Generic 2-entry valid/ready FIFO; a push into an empty FIFO is visible one cycle later.
// Backpressure: in_rdy is a decode of the occupancy register only, with no path from out_rdy.
module result_fifo2
    import adder_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_dat,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_dat
);

    fifo_state_t   state_q, state_d;
    logic          out_vld_q, out_vld_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          push;
    logic          pop;

    assign push = in_vld && in_rdy;
    assign pop  = out_vld_q && out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FIFO_EMPTY;
            out_vld_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            state_q   <= state_d;
            out_vld_q <= out_vld_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            FIFO_EMPTY: begin
                if (push) begin
                    state_d = FIFO_ONE;
                    head_d  = in_dat;
                end
            end
            FIFO_ONE: begin
                // Head is the output register, so a new entry only lands in
                // the tail slot when the current head is staying put.
                if (push && pop) begin
                    head_d = in_dat;
                end else if (push) begin
                    state_d = FIFO_FULL;
                    tail_d  = in_dat;
                end else if (pop) begin
                    state_d = FIFO_EMPTY;
                end
            end
            FIFO_FULL: begin
                if (pop) begin
                    state_d = FIFO_ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = FIFO_EMPTY;
        endcase
        out_vld_d = (state_d != FIFO_EMPTY);
    end

    always_comb begin
        in_rdy  = (state_q != FIFO_FULL);
        out_vld = out_vld_q;
        out_dat = head_q;
    end

endmodule

// File: rtl/adder_result_stage.sv
// Adder output stage: derives {V,N,Z,C} flags and buffers results; one cycle input-to-output latency.
// Backpressure: a 2-entry buffer absorbs stalls; in_ready drops only when both entries are held.
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] txn_count
);

    localparam int PW = WIDTH + FLG_W;

    logic [FLG_W-1:0] flags_in;
    logic [PW-1:0]    fifo_in_dat;
    logic [PW-1:0]    fifo_out_dat;
    logic             push;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;

    // Signed overflow: operands agree in sign but the result does not.
    always_comb begin
        flags_in        = '0;
        flags_in[FLG_C] = cout_in;
        flags_in[FLG_Z] = (sum_in == '0);
        flags_in[FLG_N] = sum_in[WIDTH-1];
        flags_in[FLG_V] = (a_msb == b_msb) && (sum_in[WIDTH-1] != a_msb);
    end

    assign fifo_in_dat = {flags_in, sum_in};
    assign push        = in_valid && in_ready;

    always_comb begin
        txn_count_d = txn_count_q;
        if (push) begin
            txn_count_d = txn_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_q <= '0;
        end else begin
            txn_count_q <= txn_count_d;
        end
    end

    result_fifo2 #(
        .DW(PW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_valid),
        .in_rdy  (in_ready),
        .in_dat  (fifo_in_dat),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (fifo_out_dat)
    );

    assign out_flags = fifo_out_dat[PW-1:WIDTH];
    assign out_sum   = fifo_out_dat[WIDTH-1:0];
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Bench for adder_result_stage: queue model checked every cycle plus literal expectations.
module tb_adder_result_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready;
    logic [W-1:0]  a_op, b_op;
    logic [W-1:0]  sum_in;
    logic          cout_in;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_sum;
    logic [3:0]    out_flags;
    logic [15:0]   txn_count;

    logic          v4, rdy4, in_ready4, out_valid4;
    logic [W-1:0]  out_sum4;
    logic [3:0]    out_flags4;
    logic [3:0]    txn_count4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign {cout_in, sum_in} = {1'b0, a_op} + {1'b0, b_op};

    adder_result_stage #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum_in(sum_in), .cout_in(cout_in), .a_msb(a_op[W-1]), .b_msb(b_op[W-1]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_flags(out_flags), .txn_count(txn_count)
    );

    adder_result_stage #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(in_ready4),
        .sum_in(32'h0000_00A5), .cout_in(1'b0), .a_msb(1'b0), .b_msb(1'b0),
        .out_valid(out_valid4), .out_ready(rdy4),
        .out_sum(out_sum4), .out_flags(out_flags4), .txn_count(txn_count4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flags from signed/unsigned arithmetic on the true operands.
    function automatic logic [35:0] model_entry(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] full;
        longint      sa, sb, ss;
        logic        v;
        full = {1'b0, a} + {1'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ss = sa + sb;
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        return {v, full[31], (full[31:0] == 32'd0), full[32], full[31:0]};
    endfunction

    logic [35:0] mq[$];
    logic [15:0] m_cnt = '0;
    int          pops = 0;
    logic        p_push = 1'b0, p_pop = 1'b0;
    logic [35:0] p_ent;

    always @(negedge clk) begin
        check("out_valid", out_valid, mq.size() != 0);
        check("in_ready", in_ready, mq.size() < 2);
        check("txn_count", txn_count, m_cnt);
        if (mq.size() != 0) begin
            check("out_sum", out_sum, mq[0][31:0]);
            check("out_flags", out_flags, mq[0][35:32]);
        end
        p_push = rst_n && in_valid && (mq.size() < 2);
        p_pop  = rst_n && out_ready && (mq.size() > 0);
        p_ent  = model_entry(a_op, b_op);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cnt  = '0;
            p_push = 1'b0;
            p_pop  = 1'b0;
        end else begin
            if (p_pop) begin
                void'(mq.pop_front());
                pops++;
            end
            if (p_push) begin
                mq.push_back(p_ent);
                m_cnt++;
            end
            p_push = 1'b0;
            p_pop  = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Upstream holds its data until accepted, with a bounded wait.
    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int   n;
        logic acc;
        n = 0;
        a_op = a;
        b_op = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[6] = '{
        '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'hC},
        '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'h3},
        '{32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0002, 4'h1},
        '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'hB},
        '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'h2},
        '{32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 4'hC}
    };

    initial begin
        time t0;
        int  pops0;
        in_valid = 1'b0; out_ready = 1'b0; a_op = '0; b_op = '0;
        v4 = 1'b0; rdy4 = 1'b1;
        repeat (3) step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, 32'h0);
        check("rst_out_flags", out_flags, 4'h0);
        check("rst_txn_count", txn_count, 16'h0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        step();

        // Flag vectors, each examined alone at the head.
        foreach (vecs[i]) begin
            push(vecs[i].a, vecs[i].b);
            check("vec_sum", out_sum, vecs[i].sum);
            check("vec_flags", out_flags, vecs[i].flags);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end

        // Backpressure: two entries fill the buffer, the third is held off.
        push(32'h11, 32'h0);
        push(32'h22, 32'h0);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_head", out_sum, 32'h11);
        a_op = 32'h33; b_op = 32'h0; in_valid = 1'b1;
        repeat (3) step();
        check("bp_txn_hold", txn_count, 16'd8);
        check("bp_head_stable", out_sum, 32'h11);
        out_ready = 1'b1;
        step();
        check("bp_second", out_sum, 32'h22);
        step();
        check("bp_third", out_sum, 32'h33);
        in_valid = 1'b0;
        step();
        check("bp_drained", out_valid, 1'b0);

        // Simultaneous push and pop with one entry held.
        out_ready = 1'b0;
        push(32'hA1, 32'h0);
        a_op = 32'hB2; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pp_valid", out_valid, 1'b1);
        check("pp_in_ready", in_ready, 1'b1);
        check("pp_head", out_sum, 32'hB2);
        out_ready = 1'b1;
        push(32'hC3, 32'h0);
        push(32'hD4, 32'h0);
        step();
        out_ready = 1'b0;

        // Reset with two entries buffered.
        push(32'h1, 32'h0);
        push(32'h2, 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_txn", txn_count, 16'h0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        check("post_rst_empty", out_valid, 1'b0);
        push(32'h5, 32'h0);
        check("post_rst_valid", out_valid, 1'b1);
        check("post_rst_sum", out_sum, 32'h5);
        out_ready = 1'b1;
        step();

        // Streaming 100 results back to back.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        pops0 = pops;
        t0 = $time;
        for (int i = 0; i < 100; i++) begin
            push(32'd1000 + 32'(i), 32'h0);
        end
        check("stream_cycles", ($time - t0) / 10, 100);
        check("stream_txn", txn_count, 16'd100);
        step();
        check("stream_pops", pops - pops0, 100);
        check("stream_empty", out_valid, 1'b0);

        // Counter wrap on the 4-bit instance.
        v4 = 1'b1;
        repeat (16) step();
        check("wrap16_txn4", txn_count4, 4'd0);
        step();
        v4 = 1'b0;
        check("wrap17_txn4", txn_count4, 4'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
